// File: rtl/sharedmem_responder_pkg.sv
// Shared definitions for the shared-memory responder: FSM encoding, default
// bank geometry and lane address field extraction.
`ifndef NUM_THREAD
`define NUM_THREAD 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LSU_NMSHRENTRY
`define LSU_NMSHRENTRY 16
`endif

package sharedmem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam int DEF_NBANK      = 8;
    localparam int DEF_BANK_DEPTH = 256;
    localparam int BANK_W         = $clog2(DEF_NBANK);
    localparam int ROW_W          = $clog2(DEF_BANK_DEPTH);

    // Word-aligned: bits [1:0] never select anything; bits above the row wrap.
    function automatic logic [BANK_W-1:0] bank_of(input logic [31:0] addr);
        return addr[2 +: BANK_W];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [31:0] addr);
        return addr[2+BANK_W +: ROW_W];
    endfunction

endpackage

// File: rtl/dualportSRAM.sv
// Single-word-wide SRAM bank: one write port with byte enables and one
// registered read port (latency 1). Contents are not reset.
module dualportSRAM #(
    parameter int  BITWIDTH = 32,
    parameter int  DEPTH    = 256,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [BITWIDTH-1:0]   wr_data,
    input  logic [BITWIDTH/8-1:0] wr_byteen,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [BITWIDTH-1:0]   rd_data
);

    logic [BITWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BITWIDTH/8; i++) begin
                if (wr_byteen[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sharedmem_responder_bank_conflict_resolver.sv
// Picks the conflict-free subset of pending lanes for one pass and builds the
// per-bank SRAM commands for it.
module bank_conflict_resolver
    import sharedmem_responder_pkg::*;
#(
    parameter int NUM_THREAD = `NUM_THREAD,
    parameter int XLEN       = `XLEN,
    parameter int NBANK      = DEF_NBANK
) (
    input  logic [NUM_THREAD-1:0]                pending,
    input  logic                                 iswrite,
    input  logic [NUM_THREAD-1:0][XLEN-1:0]      addr,
    input  logic [NUM_THREAD-1:0][XLEN-1:0]      wdata,
    input  logic [NUM_THREAD-1:0][3:0]           byteen,
    output logic [NUM_THREAD-1:0]                served,
    output logic [NBANK-1:0]                     bank_en,
    output logic [NBANK-1:0]                     bank_we,
    output logic [NBANK-1:0][ROW_W-1:0]          bank_row,
    output logic [NBANK-1:0][XLEN-1:0]           bank_wdata,
    output logic [NBANK-1:0][3:0]                bank_byteen,
    output logic [NUM_THREAD-1:0][BANK_W-1:0]    lane_bank
);

    localparam int LW = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1;

    logic [NUM_THREAD-1:0][ROW_W-1:0] lane_row;
    logic [NBANK-1:0][LW-1:0]         leader;

    always_comb begin
        lane_bank = '0;
        lane_row  = '0;
        for (int l = 0; l < NUM_THREAD; l++) begin
            lane_bank[l] = bank_of(addr[l][31:0]);
            lane_row[l]  = row_of(addr[l][31:0]);
        end
    end

    // Walk lanes high to low so the lowest pending lane ends up as bank leader.
    always_comb begin
        bank_en     = '0;
        leader      = '0;
        bank_row    = '0;
        bank_wdata  = '0;
        bank_byteen = '0;
        for (int l = NUM_THREAD-1; l >= 0; l--) begin
            if (pending[l]) begin
                bank_en[lane_bank[l]]     = 1'b1;
                leader[lane_bank[l]]      = LW'(l);
                bank_row[lane_bank[l]]    = lane_row[l];
                bank_wdata[lane_bank[l]]  = wdata[l];
                bank_byteen[lane_bank[l]] = byteen[l];
            end
        end
        bank_we = bank_en & {NBANK{iswrite}};
    end

    // Loads broadcast one row per bank; stores retire only the leader.
    always_comb begin
        served = '0;
        for (int l = 0; l < NUM_THREAD; l++) begin
            if (pending[l]) begin
                if (iswrite) served[l] = (leader[lane_bank[l]] == LW'(l));
                else         served[l] = (bank_row[lane_bank[l]] == lane_row[l]);
            end
        end
    end

endmodule

// File: rtl/sharedmem_responder.sv
// Shared-memory responder: accepts one vector request at a time, serves it in
// conflict-free passes over banked SRAM and returns one beat per pass.
module sharedmem_responder
    import sharedmem_responder_pkg::*;
#(
    parameter int  NUM_THREAD = `NUM_THREAD,
    parameter int  XLEN       = `XLEN,
    parameter int  NBANK      = DEF_NBANK,
    parameter int  BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int  NMSHR      = `LSU_NMSHRENTRY,
    localparam int IW         = $clog2(NMSHR)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [IW-1:0]                req_instrid_i,
    input  logic                         req_iswrite_i,
    input  logic [NUM_THREAD-1:0]        req_mask_i,
    input  logic [XLEN*NUM_THREAD-1:0]   req_addr_i,
    input  logic [XLEN*NUM_THREAD-1:0]   req_wdata_i,
    input  logic [4*NUM_THREAD-1:0]      req_byteen_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [IW-1:0]                rsp_instrid_o,
    output logic [XLEN*NUM_THREAD-1:0]   rsp_data_o,
    output logic [NUM_THREAD-1:0]        rsp_activemask_o
);

    state_e                               state;
    logic [NUM_THREAD-1:0]                pending;
    logic [NUM_THREAD-1:0]                served_q;
    logic [NUM_THREAD-1:0][BANK_W-1:0]    lane_bank_q;
    logic [IW-1:0]                        instrid_q;
    logic                                 iswrite_q;
    logic [NUM_THREAD-1:0][XLEN-1:0]      addr_q;
    logic [NUM_THREAD-1:0][XLEN-1:0]      wdata_q;
    logic [NUM_THREAD-1:0][3:0]           byteen_q;
    logic                                 req_ready_q;
    logic                                 rsp_valid_q;

    logic [NUM_THREAD-1:0]                served;
    logic [NBANK-1:0]                     bank_en;
    logic [NBANK-1:0]                     bank_we;
    logic [NBANK-1:0][ROW_W-1:0]          bank_row;
    logic [NBANK-1:0][XLEN-1:0]           bank_wdata;
    logic [NBANK-1:0][3:0]                bank_byteen;
    logic [NUM_THREAD-1:0][BANK_W-1:0]    lane_bank;
    logic [NBANK-1:0][XLEN-1:0]           rd_data;
    logic                                 in_access;

    assign in_access = (state == S_ACCESS);

    bank_conflict_resolver #(
        .NUM_THREAD (NUM_THREAD),
        .XLEN       (XLEN),
        .NBANK      (NBANK)
    ) u_resolver (
        .pending     (pending),
        .iswrite     (iswrite_q),
        .addr        (addr_q),
        .wdata       (wdata_q),
        .byteen      (byteen_q),
        .served      (served),
        .bank_en     (bank_en),
        .bank_we     (bank_we),
        .bank_row    (bank_row),
        .bank_wdata  (bank_wdata),
        .bank_byteen (bank_byteen),
        .lane_bank   (lane_bank)
    );

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        dualportSRAM #(
            .BITWIDTH (XLEN),
            .DEPTH    (BANK_DEPTH)
        ) u_sram (
            .clk       (clk),
            .wr_en     (in_access && bank_en[b] && bank_we[b]),
            .wr_addr   (bank_row[b]),
            .wr_data   (bank_wdata[b]),
            .wr_byteen (bank_byteen[b]),
            .rd_en     (in_access && bank_en[b] && !bank_we[b]),
            .rd_addr   (bank_row[b]),
            .rd_data   (rd_data[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pending     <= '0;
            served_q    <= '0;
            lane_bank_q <= '0;
            instrid_q   <= '0;
            iswrite_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byteen_q    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Zero-mask requests are accepted and silently dropped.
                    if (req_valid_i && req_mask_i != '0) begin
                        pending     <= req_mask_i;
                        instrid_q   <= req_instrid_i;
                        iswrite_q   <= req_iswrite_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        byteen_q    <= req_byteen_i;
                        req_ready_q <= 1'b0;
                        state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    served_q    <= served;
                    lane_bank_q <= lane_bank;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        pending     <= pending & ~served_q;
                        served_q    <= '0;
                        rsp_valid_q <= 1'b0;
                        if ((pending & ~served_q) != '0) begin
                            state <= S_ACCESS;
                        end else begin
                            state       <= S_IDLE;
                            req_ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // SRAM read registers only move in S_ACCESS, so data holds through stalls.
    always_comb begin
        rsp_data_o = '0;
        for (int l = 0; l < NUM_THREAD; l++) begin
            if (served_q[l] && !iswrite_q) rsp_data_o[l*XLEN +: XLEN] = rd_data[lane_bank_q[l]];
        end
    end

    assign req_ready_o      = req_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_instrid_o    = instrid_q;
    assign rsp_activemask_o = served_q;

endmodule

// File: tb/tb_sharedmem_responder.sv
// Bench for sharedmem_responder: directed table, random traffic against a
// queue-based bank model, and hand sequences for stall, drop and reset.
module tb_sharedmem_responder;

    localparam int NT    = 8;
    localparam int XLEN  = 32;
    localparam int NBANK = 8;
    localparam int DEPTH = 256;
    localparam int NMSHR = 16;
    localparam int IW    = 4;
    localparam int NWORD = NBANK * DEPTH;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [IW-1:0]       req_instrid_i;
    logic                req_iswrite_i;
    logic [NT-1:0]       req_mask_i;
    logic [XLEN*NT-1:0]  req_addr_i;
    logic [XLEN*NT-1:0]  req_wdata_i;
    logic [4*NT-1:0]     req_byteen_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [IW-1:0]       rsp_instrid_o;
    logic [XLEN*NT-1:0]  rsp_data_o;
    logic [NT-1:0]       rsp_activemask_o;

    always #5 clk = ~clk;

    sharedmem_responder #(
        .NUM_THREAD (NT),
        .XLEN       (XLEN),
        .NBANK      (NBANK),
        .BANK_DEPTH (DEPTH),
        .NMSHR      (NMSHR)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_instrid_i    (req_instrid_i),
        .req_iswrite_i    (req_iswrite_i),
        .req_mask_i       (req_mask_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_byteen_i     (req_byteen_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_instrid_o    (rsp_instrid_o),
        .rsp_data_o       (rsp_data_o),
        .rsp_activemask_o (rsp_activemask_o)
    );

    typedef logic [NT-1:0][31:0] vec_t;

    typedef struct {
        logic             wr;
        logic [NT-1:0]    mask;
        vec_t             addr;
        vec_t             wdata;
        int               n;
        logic [3:0][NT-1:0] m;
        vec_t             ed;
    } tvec_t;

    int vectors = 0;
    int errors  = 0;

    logic [31:0]   mem [NWORD];
    int            exp_n;
    logic [NT-1:0] exp_mask [NT+1];
    vec_t          exp_data [NT+1];

    int            obs_n;
    int            obs_lat;
    int            extra_valid;
    logic [NT-1:0] obs_mask [NT+1];
    vec_t          obs_data [NT+1];
    logic [IW-1:0] obs_id   [NT+1];

    function automatic logic [31:0] pat(input int w);
        return 32'hC0DE_0000 | w;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & (NWORD - 1));
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: one FIFO of lanes per bank; each pass serves the front lane of
    // every bank (stores) or every queued lane hitting the front lane's word (loads).
    task automatic model(input logic wr, input logic [NT-1:0] mask, input vec_t addr,
                         input vec_t wd, input logic [NT-1:0][3:0] be);
        int q [NBANK][$];
        int keep [$];
        int lead;
        int w;
        logic [NT-1:0] m;
        vec_t d;
        for (int l = 0; l < NT; l++) if (mask[l]) q[widx(addr[l]) % NBANK].push_back(l);
        exp_n = 0;
        forever begin
            m = '0;
            d = '0;
            for (int b = 0; b < NBANK; b++) begin
                if (q[b].size() == 0) continue;
                lead = q[b][0];
                w = widx(addr[lead]);
                if (wr) begin
                    void'(q[b].pop_front());
                    m[lead] = 1'b1;
                    for (int k = 0; k < 4; k++) if (be[lead][k]) mem[w][8*k +: 8] = wd[lead][8*k +: 8];
                end else begin
                    keep.delete();
                    foreach (q[b][i]) begin
                        if (widx(addr[q[b][i]]) == w) begin
                            m[q[b][i]] = 1'b1;
                            d[q[b][i]] = mem[w];
                        end else keep.push_back(q[b][i]);
                    end
                    q[b] = keep;
                end
            end
            if (m == '0) break;
            exp_mask[exp_n] = m;
            exp_data[exp_n] = d;
            exp_n++;
        end
    endtask

    // Issues one request and records every consumed beat, bounded in cycles.
    task automatic run_req(input logic [IW-1:0] id, input logic wr, input logic [NT-1:0] mask,
                           input vec_t addr, input vec_t wd, input logic [NT-1:0][3:0] be,
                           input int stall_pct);
        logic [NT-1:0] got;
        int cyc;
        @(negedge clk);
        req_valid_i   = 1'b1;
        req_instrid_i = id;
        req_iswrite_i = wr;
        req_mask_i    = mask;
        req_addr_i    = addr;
        req_wdata_i   = wd;
        req_byteen_i  = be;
        check("req_ready before accept", 256'(req_ready_o), 256'(1));
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        req_mask_i = '0;
        obs_n = 0;
        obs_lat = -1;
        extra_valid = 0;
        got = '0;
        cyc = 0;
        while ((got & mask) != mask && cyc < 100 && obs_n <= NT) begin
            @(negedge clk);
            cyc++;
            rsp_ready_i = ($urandom_range(99) >= stall_pct);
            if (rsp_valid_o) begin
                if (obs_lat < 0) obs_lat = cyc;
                if (rsp_ready_i) begin
                    obs_mask[obs_n] = rsp_activemask_o;
                    obs_data[obs_n] = rsp_data_o;
                    obs_id[obs_n]   = rsp_instrid_o;
                    got |= rsp_activemask_o;
                    obs_n++;
                end
            end
        end
        repeat (2) begin
            @(negedge clk);
            rsp_ready_i = 1'b0;
            if (rsp_valid_o) extra_valid++;
        end
    endtask

    task automatic check_vs_model(input string tag, input logic [IW-1:0] id, input logic [NT-1:0] mask);
        check({tag, " beat count"}, 256'(obs_n), 256'(exp_n));
        for (int k = 0; k < exp_n && k < obs_n; k++) begin
            check({tag, " activemask"}, 256'(obs_mask[k]), 256'(exp_mask[k]));
            check({tag, " data"}, 256'(obs_data[k]), 256'(exp_data[k]));
            check({tag, " instrid"}, 256'(obs_id[k]), 256'(id));
        end
        if (mask != '0) check({tag, " latency"}, 256'(obs_lat), 256'(2));
        check({tag, " spurious beat"}, 256'(extra_valid), 256'(0));
    endtask

    tvec_t tbl [6];

    initial begin
        logic [NT-1:0][3:0] be_all;
        vec_t a, wd, zero_v;
        logic [NT-1:0] mask;
        logic [NT-1:0][3:0] be;
        logic [NT-1:0] s_mask;
        vec_t s_data;
        logic [IW-1:0] s_id, id;
        logic wr;
        int cyc;

        be_all = '1;
        zero_v = '0;
        for (int t = 0; t < 6; t++) begin
            tbl[t].wr = 1'b0; tbl[t].addr = '0; tbl[t].wdata = '0;
            tbl[t].m = '0; tbl[t].ed = '0; tbl[t].n = 1;
        end
        tbl[0].mask = 8'hFF; tbl[0].m[0] = 8'hFF;
        for (int i = 0; i < NT; i++) begin tbl[0].addr[i] = 32'(4*i); tbl[0].ed[i] = pat(i); end
        tbl[1].mask = 8'hFF; tbl[1].m[0] = 8'hFF;
        for (int i = 0; i < NT; i++) begin tbl[1].addr[i] = 32'h40; tbl[1].ed[i] = pat(16); end
        tbl[2].mask = 8'h0F; tbl[2].n = 4;
        for (int i = 0; i < 4; i++) begin
            tbl[2].addr[i] = 32'(32*i); tbl[2].ed[i] = pat(8*i); tbl[2].m[i] = NT'(1 << i);
        end
        tbl[3].wr = 1'b1; tbl[3].mask = 8'h03; tbl[3].n = 2;
        tbl[3].addr[0] = 32'h10; tbl[3].addr[1] = 32'h10;
        tbl[3].wdata[0] = 32'hAAAA_AAAA; tbl[3].wdata[1] = 32'h5555_5555;
        tbl[3].m[0] = 8'h01; tbl[3].m[1] = 8'h02;
        tbl[4].mask = 8'h01; tbl[4].addr[0] = 32'h10; tbl[4].m[0] = 8'h01; tbl[4].ed[0] = 32'h5555_5555;
        tbl[5].mask = 8'h01; tbl[5].addr[0] = 32'h2010; tbl[5].m[0] = 8'h01; tbl[5].ed[0] = 32'h5555_5555;

        req_valid_i = 1'b0; req_instrid_i = '0; req_iswrite_i = 1'b0; req_mask_i = '0;
        req_addr_i = '0; req_wdata_i = '0; req_byteen_i = '0; rsp_ready_i = 1'b0;
        rst_n = 1'b0;
        #12;
        check("reset req_ready", 256'(req_ready_o), 256'(1));
        check("reset rsp_valid", 256'(rsp_valid_o), 256'(0));
        check("reset rsp_instrid", 256'(rsp_instrid_o), 256'(0));
        check("reset rsp_data", 256'(rsp_data_o), 256'(0));
        check("reset rsp_activemask", 256'(rsp_activemask_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Preload words 0..255 (rows 0..31 of every bank) with pat(word).
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < NT; i++) begin a[i] = 32'(32*k + 4*i); wd[i] = pat(8*k + i); end
            model(1'b1, 8'hFF, a, wd, be_all);
            run_req(IW'(k), 1'b1, 8'hFF, a, wd, be_all, 0);
            check_vs_model("preload", IW'(k), 8'hFF);
        end

        for (int t = 0; t < 6; t++) begin
            model(tbl[t].wr, tbl[t].mask, tbl[t].addr, tbl[t].wdata, be_all);
            run_req(IW'(t + 3), tbl[t].wr, tbl[t].mask, tbl[t].addr, tbl[t].wdata, be_all, 0);
            check($sformatf("table%0d beat count", t), 256'(obs_n), 256'(tbl[t].n));
            for (int k = 0; k < tbl[t].n && k < obs_n; k++) begin
                vec_t ed;
                ed = '0;
                for (int l = 0; l < NT; l++) if (tbl[t].m[k][l] && !tbl[t].wr) ed[l] = tbl[t].ed[l];
                check($sformatf("table%0d beat%0d activemask", t, k), 256'(obs_mask[k]), 256'(tbl[t].m[k]));
                check($sformatf("table%0d beat%0d data", t, k), 256'(obs_data[k]), 256'(ed));
                check($sformatf("table%0d beat%0d instrid", t, k), 256'(obs_id[k]), 256'(t + 3));
            end
            check($sformatf("table%0d latency", t), 256'(obs_lat), 256'(2));
        end

        for (int r = 0; r < 80; r++) begin
            wr   = ($urandom_range(2) == 0);
            mask = NT'($urandom());
            if ($urandom_range(9) == 0) mask = '0;
            id   = IW'($urandom());
            for (int i = 0; i < NT; i++) begin
                a[i]  = (32'($urandom_range(3)) << 5) | (32'($urandom_range(7)) << 2)
                      | ($urandom() & 32'h3) | (32'($urandom_range(7)) << 13);
                wd[i] = $urandom();
                be[i] = 4'($urandom());
            end
            model(wr, mask, a, wd, be);
            run_req(id, wr, mask, a, wd, be, 30);
            check_vs_model("random", id, mask);
        end

        // Stall: hold rsp_ready low for 5 cycles on the first beat of a 4-pass load.
        @(negedge clk);
        for (int i = 0; i < NT; i++) a[i] = (i < 4) ? 32'(32*i) : 32'h0;
        req_valid_i = 1'b1; req_instrid_i = 4'd9; req_iswrite_i = 1'b0;
        req_mask_i = 8'h0F; req_addr_i = a; req_byteen_i = '1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        req_mask_i = '0;
        rsp_ready_i = 1'b0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 10) begin @(negedge clk); cyc++; end
        check("stall first valid", 256'(rsp_valid_o), 256'(1));
        check("stall first activemask", 256'(rsp_activemask_o), 256'(8'h01));
        check("stall first data", 256'(rsp_data_o), 256'(mem[0]));
        s_mask = rsp_activemask_o; s_data = rsp_data_o; s_id = rsp_instrid_o;
        repeat (5) begin
            @(negedge clk);
            check("stall valid held", 256'(rsp_valid_o), 256'(1));
            check("stall activemask held", 256'(rsp_activemask_o), 256'(s_mask));
            check("stall data held", 256'(rsp_data_o), 256'(s_data));
            check("stall instrid held", 256'(rsp_instrid_o), 256'(s_id));
            check("stall req_ready low", 256'(req_ready_o), 256'(0));
        end
        rsp_ready_i = 1'b1;
        cyc = 0;
        while (!req_ready_o && cyc < 30) begin @(negedge clk); cyc++; end
        rsp_ready_i = 1'b0;
        check("stall drained to idle", 256'(req_ready_o), 256'(1));

        // Zero-mask request: accepted, no beat.
        @(negedge clk);
        req_valid_i = 1'b1; req_mask_i = '0; req_instrid_i = 4'd5; req_addr_i = zero_v;
        check("zero mask ready", 256'(req_ready_o), 256'(1));
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("zero mask no beat", 256'({rsp_valid_o, req_ready_o}), 256'(2'b01));
        end

        // Reset during S_RESP.
        @(negedge clk);
        req_valid_i = 1'b1; req_mask_i = 8'h0F; req_addr_i = a; req_instrid_i = 4'd7;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        req_mask_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset valid", 256'(rsp_valid_o), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid reset rsp_valid", 256'(rsp_valid_o), 256'(0));
        check("mid reset req_ready", 256'(req_ready_o), 256'(1));
        check("mid reset activemask", 256'(rsp_activemask_o), 256'(0));
        check("mid reset data", 256'(rsp_data_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sharedmem_responder.md
# sharedmem_responder

Shared-memory responder on the LSU memory side. It accepts vector load/store requests tagged with an MSHR entry index, resolves bank conflicts across threads, and performs the accesses on banked single-word SRAM. Each conflict-free pass returns one response beat: `instrid`, `data` and `activemask`. The MSHR ANDs `~activemask` into the entry's pending mask and retires the entry when that mask reaches zero.

## Interface
Parameters:
- `NUM_THREAD`, default `` `NUM_THREAD `` (8): lanes per request.
- `XLEN`, default `` `XLEN `` (32): word width.
- `NBANK`, default 8: SRAM banks (power of 2). One word per bank per cycle.
- `BANK_DEPTH`, default 256: words per bank (power of 2).
- `NMSHR`, default `` `LSU_NMSHRENTRY ``: instrid range. `IW = $clog2(NMSHR)`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_instrid_i`  in  IW  MSHR entry index; echoed on every response beat.
- `req_iswrite_i`  in  1  1 = store, 0 = load.
- `req_mask_i`  in  NUM_THREAD  active lanes.
- `req_addr_i`  in  XLEN*NUM_THREAD  per-lane byte address. Bits [1:0] ignored.
- `req_wdata_i`  in  XLEN*NUM_THREAD  per-lane store data.
- `req_byteen_i`  in  4*NUM_THREAD  per-lane store byte enables.
- `rsp_valid_o`  out  1  response beat valid.
- `rsp_ready_i`  in  1  response beat ready.
- `rsp_instrid_o`  out  IW  entry index.
- `rsp_data_o`  out  XLEN*NUM_THREAD  load data for served lanes; 0 for stores and unserved lanes.
- `rsp_activemask_o`  out  NUM_THREAD  lanes served in this beat.

## Operation
Address fields per lane:
- `bank = addr[2 +: log2(NBANK)]`.
- `row = addr[2+log2(NBANK) +: log2(BANK_DEPTH)]`.
- Higher bits ignored, so addresses wrap modulo bank capacity.

FSM states are `S_IDLE`, `S_ACCESS` and `S_RESP`.
- **S_IDLE**: `req_ready_o` = 1.
  - On handshake with nonzero `req_mask_i`: latch the whole request, set `pending = req_mask_i`, go to `S_ACCESS`.
  - On handshake with `req_mask_i == 0`: accept and drop. Stay in `S_IDLE`; no response.
- **S_ACCESS**: resolve conflicts over `pending`.
  - Per bank, the leader is the lowest-index pending lane mapping to that bank.
  - Load: served = every pending lane whose bank has a leader and whose row equals that leader's row (broadcast).
  - Store: served = leaders only.
  - Perform the SRAM reads/writes for the served set this cycle. Stores use byte enables.
  - Register `served`. Go to `S_RESP`.
- **S_RESP**: drive `rsp_valid_o` = 1 with `rsp_activemask_o = served` and the SRAM read data per lane. Unserved lanes output 0.
  - On `rsp_ready_i`: `pending &= ~served`. Go to `S_ACCESS` if `pending != 0`, else `S_IDLE`.
  - Without `rsp_ready_i`: all `rsp_*` outputs are held stable.
- Each pass serves at least one lane, so a request finishes in at most NUM_THREAD passes.
- The union of all `activemask` beats for one request equals `req_mask_i` exactly; beats are disjoint.

## Timing
- Reset values: state `S_IDLE`, `pending` = 0. Outputs: `req_ready_o` = 1, `rsp_valid_o` = 0, `rsp_instrid_o` = 0, `rsp_data_o` = 0, `rsp_activemask_o` = 0. SRAM contents are undefined.
- Request accepted at edge N → `S_ACCESS` in cycle N+1 → `rsp_valid_o` in cycle N+2 (SRAM read latency 1).
- Each extra pass costs 2 cycles plus any `rsp_ready_i` stall cycles.
- Only one request is in flight; `req_ready_o` = 0 outside `S_IDLE`.
- Read-after-write across requests sees the new data: the write happens in `S_ACCESS`, before any later request can be accepted.
- Reset asserted mid-operation: immediate return to `S_IDLE`, in-flight request lost, `rsp_valid_o` drops asynchronously.

## Structure
- Shared package holds:
  - FSM state encoding.
  - `BANK_W`/`ROW_W` localparams and bank/row field-extract functions.
- Sub-module `bank_conflict_resolver`: combinational. Takes `pending`, lane addresses and `iswrite`; produces the served mask plus per-bank `{en, we, row, wdata, byteen}` and the per-lane source-bank select.
- Banks: NBANK instances of the existing `dualportSRAM` (BITWIDTH = XLEN).

## Test plan
- Load, 8 lanes, addresses 0x00,0x04,…,0x1C (all distinct banks) → one beat 2 cycles after accept, activemask 0xFF, data = preloaded words.
- Load, all 8 lanes at address 0x40 → one beat, activemask 0xFF, all lanes carry the same word.
- Load, lanes 0–3 at 0x000,0x020,0x040,0x060 (bank 0, rows 0–3), mask 0x0F → four beats with activemask 0x1,0x2,0x4,0x8; `instrid` constant.
- Store, lanes 0 and 1 both at 0x10, byteen 0xF, data 0xAAAA_AAAA / 0x5555_5555, then load 0x10 → two store beats (0x1, then 0x2); the load returns 0x5555_5555.
- `rsp_ready_i` held low for 5 cycles in `S_RESP` → outputs stable, `req_ready_o` = 0. Then a `req_mask_i` = 0 request → accepted, no response. Then reset asserted mid-pass → `rsp_valid_o` = 0, `req_ready_o` = 1.
